// File: rtl/cache_pkg.sv
// Shared types, default geometry and address-field helpers for the direct-mapped data cache.
package cache_pkg;

    localparam int INDEX_BITS_DEF  = 4;
    localparam int OFFSET_BITS_DEF = 2;
    localparam int TAG_BITS        = 32 - INDEX_BITS_DEF - OFFSET_BITS_DEF - 2;
    localparam int WORDS           = 1 << OFFSET_BITS_DEF;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REFILL = 2'd1,
        WRITE  = 2'd2
    } cache_state_e;

    // Word-in-line field; byte bits [1:0] are dropped.
    function automatic logic [31:0] addr_offset(input logic [31:0] addr, input int offset_bits);
        return (addr >> 2) & ((32'd1 << offset_bits) - 32'd1);
    endfunction

    // Line index field sitting directly above the word offset.
    function automatic logic [31:0] addr_index(input logic [31:0] addr, input int index_bits,
                                               input int offset_bits);
        return (addr >> (offset_bits + 2)) & ((32'd1 << index_bits) - 32'd1);
    endfunction

    // Everything above the index is the tag.
    function automatic logic [31:0] addr_tag(input logic [31:0] addr, input int index_bits,
                                             input int offset_bits);
        return addr >> (index_bits + offset_bits + 2);
    endfunction

endpackage

// File: rtl/dcache_array.sv
// Tag, valid and data storage for the direct-mapped cache: combinational read, synchronous write.
module dcache_array
    import cache_pkg::*;
#(
    parameter int INDEX_BITS  = INDEX_BITS_DEF,
    parameter int OFFSET_BITS = OFFSET_BITS_DEF,
    parameter int TAG_W       = TAG_BITS
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [INDEX_BITS-1:0]  index,
    input  logic [OFFSET_BITS-1:0] rd_offset,
    output logic                   rd_valid,
    output logic [TAG_W-1:0]       rd_tag,
    output logic [31:0]            rd_data,
    input  logic                   data_we,
    input  logic [OFFSET_BITS-1:0] wr_offset,
    input  logic [31:0]            wr_data,
    input  logic                   tag_we,
    input  logic [TAG_W-1:0]       wr_tag,
    input  logic                   valid_set,
    input  logic                   valid_clr
);

    localparam int LINES = 1 << INDEX_BITS;

    logic [LINES-1:0] valid_q;
    logic [TAG_W-1:0] tag_mem  [LINES];
    logic [31:0]      data_mem [LINES * (1 << OFFSET_BITS)];

    assign rd_valid = valid_q[index];
    assign rd_tag   = tag_mem[index];
    assign rd_data  = data_mem[{index, rd_offset}];

    // Valid bits are the only state wiped by reset; clearing wins so a refill start always invalidates.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= '0;
        end else if (valid_clr) begin
            valid_q[index] <= 1'b0;
        end else if (valid_set) begin
            valid_q[index] <= 1'b1;
        end
    end

    // Tag and data arrays are plain storage with no reset.
    always_ff @(posedge clk) begin
        if (tag_we) begin
            tag_mem[index] <= wr_tag;
        end
        if (data_we) begin
            data_mem[{index, wr_offset}] <= wr_data;
        end
    end

endmodule

// File: rtl/dcache_direct.sv
// Direct-mapped write-through, no-write-allocate data cache with line refill and word write-through.
module dcache_direct
    import cache_pkg::*;
#(
    parameter int INDEX_BITS  = INDEX_BITS_DEF,
    parameter int OFFSET_BITS = OFFSET_BITS_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_read,
    input  logic        cpu_write,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic [31:0] cpu_rdata,
    output logic        cpu_stall,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack
);

    localparam int                     TAG_W     = 30 - INDEX_BITS - OFFSET_BITS;
    localparam int                     LOW_BITS  = OFFSET_BITS + 2;
    localparam logic [OFFSET_BITS-1:0] LAST_BEAT = '1;

    cache_state_e           state_q, state_d;
    logic [31:0]            addr_q, addr_d;
    logic [31:0]            wdata_q, wdata_d;
    logic [OFFSET_BITS-1:0] beat_q, beat_d;

    logic [31:0]            look_addr;
    logic [INDEX_BITS-1:0]  look_index;
    logic [OFFSET_BITS-1:0] look_offset;
    logic [TAG_W-1:0]       look_tag;
    logic                   line_valid;
    logic [TAG_W-1:0]       line_tag;
    logic [31:0]            line_word;
    logic                   hit;
    logic                   data_we, tag_we, valid_set, valid_clr;
    logic [OFFSET_BITS-1:0] wr_offset;
    logic [31:0]            wr_data;

    // While idle the array is probed with the live CPU address; otherwise with the latched one.
    assign look_addr   = (state_q == IDLE) ? cpu_addr : addr_q;
    assign look_index  = INDEX_BITS'(addr_index(look_addr, INDEX_BITS, OFFSET_BITS));
    assign look_offset = OFFSET_BITS'(addr_offset(look_addr, OFFSET_BITS));
    assign look_tag    = TAG_W'(addr_tag(look_addr, INDEX_BITS, OFFSET_BITS));
    assign hit         = line_valid && (line_tag == look_tag);

    // Refill writes the beat slot with memory data; a write hit updates the addressed word.
    assign wr_offset = (state_q == REFILL) ? beat_q : look_offset;
    assign wr_data   = (state_q == REFILL) ? mem_rdata : wdata_q;

    dcache_array #(
        .INDEX_BITS  (INDEX_BITS),
        .OFFSET_BITS (OFFSET_BITS),
        .TAG_W       (TAG_W)
    ) u_array (
        .clk       (clk),
        .rst       (rst),
        .index     (look_index),
        .rd_offset (look_offset),
        .rd_valid  (line_valid),
        .rd_tag    (line_tag),
        .rd_data   (line_word),
        .data_we   (data_we),
        .wr_offset (wr_offset),
        .wr_data   (wr_data),
        .tag_we    (tag_we),
        .wr_tag    (look_tag),
        .valid_set (valid_set),
        .valid_clr (valid_clr)
    );

    // Next-state logic for the controller, latches, beat counter and array write strobes.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        beat_d    = beat_q;
        data_we   = 1'b0;
        tag_we    = 1'b0;
        valid_set = 1'b0;
        valid_clr = 1'b0;
        case (state_q)
            IDLE: begin
                if (cpu_write) begin
                    addr_d  = {cpu_addr[31:2], 2'b00};
                    wdata_d = cpu_wdata;
                    state_d = WRITE;
                end else if (cpu_read && !hit) begin
                    addr_d    = {cpu_addr[31:LOW_BITS], {LOW_BITS{1'b0}}};
                    beat_d    = '0;
                    valid_clr = 1'b1;
                    state_d   = REFILL;
                end
            end
            REFILL: begin
                if (mem_ack) begin
                    data_we = 1'b1;
                    beat_d  = beat_q + 1'b1;
                    if (beat_q == LAST_BEAT) begin
                        valid_set = 1'b1;
                        tag_we    = 1'b1;
                        state_d   = IDLE;
                    end
                end
            end
            WRITE: begin
                if (mem_ack) begin
                    data_we = hit;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Controller registers; reset abandons any beat in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            beat_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            beat_q  <= beat_d;
        end
    end

    // Core-side stall: misses and stores hold the core until the memory side is finished.
    always_comb begin
        cpu_stall = 1'b0;
        case (state_q)
            IDLE:    cpu_stall = cpu_write || (cpu_read && !hit);
            REFILL:  cpu_stall = 1'b1;
            WRITE:   cpu_stall = !mem_ack;
            default: cpu_stall = 1'b0;
        endcase
    end

    assign cpu_rdata = (state_q == IDLE && cpu_read && !cpu_write && hit) ? line_word : '0;

    // Memory-side outputs decode purely from registered state so they hold steady until acked.
    assign mem_req   = (state_q != IDLE);
    assign mem_we    = (state_q == WRITE);
    assign mem_addr  = (state_q == REFILL) ? {addr_q[31:LOW_BITS], beat_q, 2'b00} :
                       (state_q == WRITE)  ? addr_q : '0;
    assign mem_wdata = (state_q == WRITE) ? wdata_q : '0;

endmodule

// File: tb/tb_dcache_direct.sv
// Self-checking bench for dcache_direct: directed scenarios plus randomized traffic against a cache model.
module tb_dcache_direct;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        cpu_read = 1'b0;
    logic        cpu_write = 1'b0;
    logic [31:0] cpu_addr = '0;
    logic [31:0] cpu_wdata = '0;
    logic [31:0] cpu_rdata;
    logic        cpu_stall;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = '0;
    logic        mem_ack = 1'b0;

    int tests = 0;
    int fails = 0;

    // Backing memory: written words override a fixed pseudo-random fill pattern.
    logic [31:0] memW [logic [31:0]];

    // Observations from the most recent CPU access.
    int          obsStall;
    logic [31:0] obsRdata;
    logic [31:0] beatAddr [$];
    bit          beatWe [$];
    logic [31:0] beatData [$];

    // Cache model: which tag each line holds, if any.
    bit          mValid [16];
    logic [23:0] mTag [16];

    dcache_direct dut (
        .clk       (clk),
        .rst       (rst),
        .cpu_read  (cpu_read),
        .cpu_write (cpu_write),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_rdata (cpu_rdata),
        .cpu_stall (cpu_stall),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_read(input logic [31:0] a);
        if (memW.exists(a)) return memW[a];
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0000;
    endfunction

    // Runs one CPU access to completion, acting as memory that acks each beat after 'lat' request cycles.
    task automatic cpu_access(input bit rd, input bit wr, input logic [31:0] addr,
                              input logic [31:0] wdata, input int lat);
        int waitCnt;
        bit done;
        beatAddr.delete();
        beatWe.delete();
        beatData.delete();
        obsStall = 0;
        obsRdata = '0;
        waitCnt  = 0;
        done     = 1'b0;
        cpu_read  = rd;
        cpu_write = wr;
        cpu_addr  = addr;
        cpu_wdata = wdata;
        for (int cyc = 0; cyc < 100 && !done; cyc++) begin
            @(negedge clk);
            if (mem_req) begin
                waitCnt++;
                if (waitCnt >= lat) begin
                    mem_ack = 1'b1;
                    beatAddr.push_back(mem_addr);
                    beatWe.push_back(mem_we);
                    beatData.push_back(mem_wdata);
                    if (mem_we) memW[mem_addr] = mem_wdata;
                    else mem_rdata = mem_read(mem_addr);
                    waitCnt = 0;
                end
            end
            #1;
            if (!cpu_stall) begin
                done = 1'b1;
                obsRdata = cpu_rdata;
            end else begin
                obsStall++;
            end
            @(posedge clk);
            #1;
            mem_ack   = 1'b0;
            mem_rdata = '0;
        end
        cpu_read  = 1'b0;
        cpu_write = 1'b0;
        tests++;
        if (!done) begin
            fails++;
            $display("[TB] FAIL access_timeout: addr %h still stalled after 100 cycles, required completion", addr);
        end
    endtask

    task automatic pulse_reset();
        rst = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        for (int i = 0; i < 16; i++) mValid[i] = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #3;
        tests++; if (mem_req !== 1'b0) begin fails++; $display("[TB] FAIL reset_mem_req: got %b need 0", mem_req); end
        tests++; if (mem_we !== 1'b0) begin fails++; $display("[TB] FAIL reset_mem_we: got %b need 0", mem_we); end
        tests++; if (mem_addr !== 32'h0) begin fails++; $display("[TB] FAIL reset_mem_addr: got %h need 0", mem_addr); end
        tests++; if (mem_wdata !== 32'h0) begin fails++; $display("[TB] FAIL reset_mem_wdata: got %h need 0", mem_wdata); end
        tests++; if (cpu_stall !== 1'b0) begin fails++; $display("[TB] FAIL reset_stall: got %b need 0", cpu_stall); end
        tests++; if (cpu_rdata !== 32'h0) begin fails++; $display("[TB] FAIL reset_rdata: got %h need 0", cpu_rdata); end
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic test_read_miss();
        cpu_access(1'b1, 1'b0, 32'h40, '0, 1);
        tests++; if (obsStall !== 5) begin fails++; $display("[TB] FAIL miss_stall: got %0d need 5", obsStall); end
        tests++; if (beatAddr.size() !== 4) begin fails++; $display("[TB] FAIL miss_beats: got %0d need 4", beatAddr.size()); end
        for (int i = 0; i < beatAddr.size() && i < 4; i++) begin
            tests++;
            if (beatAddr[i] !== 32'h40 + 4 * i || beatWe[i] !== 1'b0) begin
                fails++;
                $display("[TB] FAIL miss_beat%0d: got addr %h we %b need addr %h we 0", i, beatAddr[i], beatWe[i], 32'h40 + 4 * i);
            end
        end
        tests++; if (obsRdata !== 32'hA0) begin fails++; $display("[TB] FAIL miss_replay_data: got %h need 000000a0", obsRdata); end
        cpu_access(1'b1, 1'b0, 32'h48, '0, 1);
        tests++; if (obsStall !== 0 || beatAddr.size() !== 0) begin fails++; $display("[TB] FAIL hit_stall: got stall %0d beats %0d need 0 0", obsStall, beatAddr.size()); end
        tests++; if (obsRdata !== 32'hA2) begin fails++; $display("[TB] FAIL hit_data: got %h need 000000a2", obsRdata); end
    endtask

    task automatic test_write_hit();
        cpu_access(1'b0, 1'b1, 32'h44, 32'hDEAD_BEEF, 3);
        tests++; if (obsStall !== 3) begin fails++; $display("[TB] FAIL whit_stall: got %0d need 3", obsStall); end
        tests++;
        if (beatAddr.size() !== 1 || beatAddr[0] !== 32'h44 || beatWe[0] !== 1'b1 || beatData[0] !== 32'hDEAD_BEEF) begin
            fails++;
            $display("[TB] FAIL whit_beat: got %0d beats, need one write beat 44=deadbeef", beatAddr.size());
        end
        cpu_access(1'b1, 1'b0, 32'h44, '0, 1);
        tests++; if (obsStall !== 0) begin fails++; $display("[TB] FAIL whit_read_stall: got %0d need 0", obsStall); end
        tests++; if (obsRdata !== 32'hDEAD_BEEF) begin fails++; $display("[TB] FAIL whit_read_data: got %h need deadbeef", obsRdata); end
    endtask

    task automatic test_write_miss();
        cpu_access(1'b0, 1'b1, 32'h1000, 32'h1234_5678, 2);
        tests++; if (obsStall !== 2) begin fails++; $display("[TB] FAIL wmiss_stall: got %0d need 2", obsStall); end
        tests++;
        if (beatAddr.size() !== 1 || beatAddr[0] !== 32'h1000 || beatWe[0] !== 1'b1) begin
            fails++;
            $display("[TB] FAIL wmiss_beat: got %0d beats, need one write beat at 1000", beatAddr.size());
        end
        cpu_access(1'b1, 1'b0, 32'h1000, '0, 1);
        tests++; if (obsStall !== 5 || beatAddr.size() !== 4) begin fails++; $display("[TB] FAIL wmiss_refill: got stall %0d beats %0d need 5 4", obsStall, beatAddr.size()); end
        tests++; if (obsRdata !== 32'h1234_5678) begin fails++; $display("[TB] FAIL wmiss_read_data: got %h need 12345678", obsRdata); end
    endtask

    task automatic test_conflict();
        cpu_access(1'b1, 1'b0, 32'h140, '0, 1);
        tests++;
        if (obsStall !== 5 || beatAddr.size() !== 4 || beatAddr[0] !== 32'h140) begin
            fails++;
            $display("[TB] FAIL conflict_refill: got stall %0d beats %0d need 5 4 from 140", obsStall, beatAddr.size());
        end
        tests++; if (obsRdata !== mem_read(32'h140)) begin fails++; $display("[TB] FAIL conflict_data: got %h need %h", obsRdata, mem_read(32'h140)); end
        cpu_access(1'b1, 1'b0, 32'h40, '0, 2);
        tests++; if (obsStall !== 9 || beatAddr.size() !== 4) begin fails++; $display("[TB] FAIL conflict_evicted: got stall %0d beats %0d need 9 4", obsStall, beatAddr.size()); end
        tests++; if (obsRdata !== 32'hA0) begin fails++; $display("[TB] FAIL conflict_reload: got %h need 000000a0", obsRdata); end
    endtask

    task automatic test_read_write_same();
        cpu_access(1'b1, 1'b1, 32'h80, 32'hCAFE_F00D, 1);
        tests++;
        if (obsStall !== 1 || beatAddr.size() !== 1 || beatWe[0] !== 1'b1 || beatAddr[0] !== 32'h80) begin
            fails++;
            $display("[TB] FAIL both_write_only: got stall %0d beats %0d need 1 1 write at 80", obsStall, beatAddr.size());
        end
        cpu_access(1'b1, 1'b0, 32'h80, '0, 1);
        tests++; if (obsStall !== 5 || obsRdata !== 32'hCAFE_F00D) begin fails++; $display("[TB] FAIL both_then_read: got stall %0d data %h need 5 cafef00d", obsStall, obsRdata); end
    endtask

    task automatic test_reset_mid_refill();
        int beats = 0;
        cpu_read = 1'b1;
        cpu_addr = 32'h200;
        for (int cyc = 0; cyc < 20 && beats < 2; cyc++) begin
            @(negedge clk);
            if (mem_req) begin
                mem_ack   = 1'b1;
                mem_rdata = mem_read(mem_addr);
                beats++;
            end
            @(posedge clk);
            #1;
            mem_ack = 1'b0;
        end
        @(negedge clk);
        tests++; if (mem_req !== 1'b1 || mem_addr !== 32'h208) begin fails++; $display("[TB] FAIL midfill_beat2: got req %b addr %h need 1 208", mem_req, mem_addr); end
        rst = 1'b0;
        cpu_read = 1'b0;
        #1;
        tests++; if (mem_req !== 1'b0 || mem_addr !== 32'h0) begin fails++; $display("[TB] FAIL midfill_drop: got req %b addr %h need 0 0", mem_req, mem_addr); end
        tests++; if (cpu_stall !== 1'b0 || cpu_rdata !== 32'h0) begin fails++; $display("[TB] FAIL midfill_cpu: got stall %b data %h need 0 0", cpu_stall, cpu_rdata); end
        @(posedge clk);
        #1;
        rst = 1'b1;
        cpu_access(1'b1, 1'b0, 32'h200, '0, 1);
        tests++;
        if (obsStall !== 5 || beatAddr.size() !== 4 || beatAddr[0] !== 32'h200 || obsRdata !== mem_read(32'h200)) begin
            fails++;
            $display("[TB] FAIL midfill_retry: got stall %0d beats %0d data %h need 5 4 %h", obsStall, beatAddr.size(), obsRdata, mem_read(32'h200));
        end
        cpu_access(1'b1, 1'b0, 32'h40, '0, 1);
        tests++; if (obsStall !== 5) begin fails++; $display("[TB] FAIL midfill_valid_cleared: got stall %0d need 5", obsStall); end
    endtask

    task automatic test_random();
        pulse_reset();
        for (int n = 0; n < 120; n++) begin
            logic [31:0] addr, wdata, expData, base;
            logic [3:0]  idx;
            logic [23:0] tg;
            int          op, lat, expStall, expBeats;
            bit          rd, wr, isHit;
            addr  = (32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(0, 15)) << 4) |
                    (32'($urandom_range(0, 3)) << 2) | 32'($urandom_range(0, 3));
            op    = int'($urandom_range(0, 3));
            lat   = int'($urandom_range(1, 3));
            wdata = $urandom();
            wr    = (op <= 1);
            rd    = (op >= 1);
            idx   = addr[7:4];
            tg    = addr[31:8];
            base  = {addr[31:4], 4'h0};
            isHit = mValid[idx] && (mTag[idx] == tg);
            expData = mem_read({addr[31:2], 2'b00});
            if (wr) begin
                expStall = lat;
                expBeats = 1;
            end else if (isHit) begin
                expStall = 0;
                expBeats = 0;
            end else begin
                expStall = 1 + 4 * lat;
                expBeats = 4;
            end
            cpu_access(rd, wr, addr, wdata, lat);
            tests++;
            if (obsStall !== expStall || beatAddr.size() !== expBeats) begin
                fails++;
                $display("[TB] FAIL rand%0d_timing: addr %h op %0d got stall %0d beats %0d need %0d %0d",
                         n, addr, op, obsStall, beatAddr.size(), expStall, expBeats);
            end
            for (int i = 0; i < beatAddr.size() && i < expBeats; i++) begin
                tests++;
                if (wr ? (beatAddr[i] !== {addr[31:2], 2'b00} || beatWe[i] !== 1'b1 || beatData[i] !== wdata)
                       : (beatAddr[i] !== base + 4 * i || beatWe[i] !== 1'b0)) begin
                    fails++;
                    $display("[TB] FAIL rand%0d_beat%0d: got addr %h we %b data %h", n, i, beatAddr[i], beatWe[i], beatData[i]);
                end
            end
            if (!wr) begin
                tests++;
                if (obsRdata !== expData) begin
                    fails++;
                    $display("[TB] FAIL rand%0d_data: addr %h got %h need %h", n, addr, obsRdata, expData);
                end
                mValid[idx] = 1'b1;
                mTag[idx]   = tg;
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 4; i++) memW[32'h40 + 32'(4 * i)] = 32'hA0 + 32'(i);
        test_reset();
        test_read_miss();
        test_write_hit();
        test_write_miss();
        test_conflict();
        test_read_write_same();
        test_reset_mid_refill();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/dcache_direct.md
# dcache_direct

Direct-mapped, write-through, no-write-allocate data cache placed between the single-cycle MIPS core's data port and a slower handshaked backing memory. Read hits return data in the same cycle. Misses and all stores stall the core through `cpu_stall` while the cache runs line refills or word write-throughs against memory.

## Interface
Parameters:
- `INDEX_BITS`, 4: line index width (16 lines)
- `OFFSET_BITS`, 2: word-in-line width (4 words of 32 bits per line)

Ports:
- `clk` in 1: single clock, rising edge
- `rst` in 1: reset, asynchronous, active-low
- `cpu_read` in 1: load request
- `cpu_write` in 1: store request (wins if both asserted; the read is ignored)
- `cpu_addr` in 32: byte address; bits [1:0] ignored
- `cpu_wdata` in 32: store data
- `cpu_rdata` out 32: load data, valid when `cpu_read` & !`cpu_stall`
- `cpu_stall` out 1: core must hold PC and request stable while high
- `mem_req` out 1: memory beat request
- `mem_we` out 1: 1 = write beat, 0 = read beat
- `mem_addr` out 32: word-aligned beat address
- `mem_wdata` out 32: write beat data
- `mem_rdata` in 32: read beat data, valid with `mem_ack`
- `mem_ack` in 1: beat complete this cycle

## Operation
- Address split: offset [OFFSET_BITS+1:2], index [INDEX_BITS+OFFSET_BITS+1:OFFSET_BITS+2], tag = remaining upper bits (24 with defaults).
- Hit condition: `valid[index]` and `tag[index] == addr tag`.
- FSM states: IDLE, REFILL, WRITE.
- IDLE:
  - Read hit: `cpu_rdata` = data[index][offset] combinationally, `cpu_stall` = 0.
  - Read miss: `cpu_stall` = 1. Latch line base address (offset = 0). Clear beat counter. Go to REFILL.
  - Write: `cpu_stall` = 1. Latch address and data. Go to WRITE.
  - No request: `cpu_stall` = 0, `mem_req` = 0.
- REFILL:
  - `mem_req` = 1, `mem_we` = 0, `mem_addr` = base + 4*beat.
  - Each cycle with `mem_ack`: write `mem_rdata` into data[index][beat], then beat++.
  - On the ack of the last beat (beat = 2^OFFSET_BITS−1): set valid, write tag, go to IDLE.
  - `cpu_stall` = 1 throughout. The replay cycle in IDLE then hits.
  - Valid for the index is cleared on REFILL entry, so a partially filled line never hits.
- WRITE:
  - `mem_req` = 1, `mem_we` = 1, `mem_addr`/`mem_wdata` = latched values.
  - `cpu_stall` = !`mem_ack`.
  - On `mem_ack`: if the latched address hits, update the cached word. Go to IDLE.
  - Write miss does not allocate.
- Handshake:
  - `mem_req`, `mem_we`, `mem_addr`, `mem_wdata` stay stable until `mem_ack`.
  - `mem_req` may remain high across consecutive refill beats; one beat completes per acked cycle.
  - `mem_ack` while `mem_req` = 0 is ignored.
- Reset (any time, including mid-refill or mid-write):
  - Valid bits cleared, state IDLE, beat counter 0.
  - `mem_req` = 0, `mem_we` = 0, `mem_addr` = 0, `mem_wdata` = 0.
  - `cpu_stall` = 0 when no request is asserted, and `cpu_rdata` = 0 as long as `cpu_read` is low.
  - Tag and data arrays are not reset.
  - A beat in flight is abandoned; memory tolerates the dropped request.

## Timing
- Read hit: 0 added cycles.
- Read miss: 1 IDLE cycle + N cycles to collect 4 acks + 1 replay hit cycle. With ack every cycle: 6 cycles total, stall high for 5.
- Store: minimum 2 cycles (IDLE detect + WRITE ack cycle). Stall is high for 1 + (cycles until ack − 1).
- FSM, latched address/data, beat counter and valid bits are registered.
- `cpu_stall` and `cpu_rdata` are combinational from registered state and the CPU inputs.
- Memory outputs come from registered state only.

## Structure
- Package `cache_pkg`:
  - State enum (IDLE/REFILL/WRITE).
  - Default `INDEX_BITS`/`OFFSET_BITS`, derived `TAG_BITS` and `WORDS` constants.
  - Address-field extraction functions.
- Sub-module `dcache_array`:
  - Tag, valid and data storage.
  - Combinational read, synchronous word write.
  - Async valid clear on reset.
- FSM, beat counter and latches live in `dcache_direct`.

## Test plan
- Reset, then read 0x0000_0040 with memory returning 0xA0..0xA3 for words 0x40..0x4C, ack every cycle → `mem_addr` sequence 0x40, 0x44, 0x48, 0x4C; stall high 5 cycles; `cpu_rdata` = 0xA0 on replay. A following read of 0x48 hits with data 0xA2 and no stall.
- Write 0x0000_0044 = 0xDEAD_BEEF to a valid line, ack after 3 cycles → one write beat at 0x44 with `mem_we` = 1; stall high 3 cycles. A later read of 0x44 hits with 0xDEAD_BEEF.
- Write miss to 0x0000_1000 → one write beat only, no refill. A later read of 0x1000 misses and refills.
- Conflict: fill line for 0x40, then read 0x0000_0140 (same index, new tag) → refill replaces the line. Read 0x40 then misses.
- Assert `rst` low during beat 2 of a refill → `mem_req` drops immediately. After release, the read to the same address does a full 4-beat refill.
- `cpu_read` and `cpu_write` both high on the same address → only a write beat is issued; no refill.
